// File: rtl/sprite_line_renderer_pkg.sv
// rtl/sprite_line_renderer_pkg.sv - shared beam timing constants and renderer state encoding
package sprite_line_renderer_pkg;

  // Beam timing shared with hvsync_generator.
  localparam logic [9:0] H_DISPLAY = 10'd640;
  localparam logic [9:0] H_MAX     = 10'd799;
  localparam logic [9:0] V_DISPLAY = 10'd480;
  localparam logic [9:0] V_MAX     = 10'd524;

  // Bitmap geometry: 8 pixels wide, 16 rows tall.
  localparam logic [9:0] SPRITE_ROWS = 10'd16;
  localparam logic [9:0] OFFSCREEN   = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ARMED = 3'd3,
    ST_DRAW  = 3'd4
  } state_t;

  // Beam counter successor with wrap at the last position.
  function automatic logic [9:0] next_pos(input logic [9:0] pos, input logic [9:0] last);
    return (pos == last) ? 10'd0 : pos + 10'd1;
  endfunction

endpackage

// File: rtl/sprite_line_renderer_if.sv
// rtl/sprite_line_renderer_if.sv - bitmap ROM bus between renderer and the external sprite ROM
interface sprite_line_renderer_if;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - single 8x16 sprite scanline renderer driven by beam position
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 hpos,
  input  logic [9:0]                 vpos,
  input  logic [9:0]                 sprite_x,
  input  logic [9:0]                 sprite_y,
  sprite_line_renderer_if.master     rom,
  output logic                       gfx,
  output logic                       busy
);

  logic [9:0] x_lat, y_lat;
  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] addr_q, addr_n;
  logic       gfx_n;

  logic       frame_latch, line_trig, hit, visible_next;
  logic [9:0] t, r, hn;

  assign frame_latch  = (vpos == V_DISPLAY) && (hpos == 10'd0);
  assign line_trig    = (hpos == H_DISPLAY);
  assign t            = next_pos(vpos, V_MAX);
  assign r            = t - y_lat;
  assign hit          = (t >= y_lat) && (r < SPRITE_ROWS) && (t < V_DISPLAY);
  // gfx is registered, so the pixel being computed now appears at column hn.
  assign hn           = next_pos(hpos, H_MAX);
  assign visible_next = (hn < H_DISPLAY);

  assign rom.rom_addr = addr_q;
  assign busy         = (state != ST_IDLE);

  // Capture sprite position once per frame so a move never tears mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_lat <= OFFSCREEN;
      y_lat <= OFFSCREEN;
    end else if (frame_latch) begin
      x_lat <= sprite_x;
      y_lat <= sprite_y;
    end
  end

  // Next-state and datapath: the line trigger overrides whatever is in flight.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    addr_n  = addr_q;
    gfx_n   = 1'b0;
    if (line_trig) begin
      if (hit) begin
        state_n = ST_FETCH;
        addr_n  = r[3:0];
      end else begin
        state_n = ST_IDLE;
      end
    end else begin
      case (state)
        ST_FETCH: state_n = ST_LOAD;
        ST_LOAD: begin
          shreg_n = rom.rom_data;
          state_n = ST_ARMED;
        end
        ST_ARMED: begin
          if (hn == x_lat) begin
            gfx_n   = shreg[7] & visible_next;
            shreg_n = {shreg[6:0], 1'b0};
            cnt_n   = 3'd7;
            state_n = ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (cnt != 3'd0) begin
            gfx_n   = shreg[7] & visible_next;
            shreg_n = {shreg[6:0], 1'b0};
            cnt_n   = cnt - 3'd1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset discards any in-flight row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= 8'd0;
      cnt    <= 3'd0;
      addr_q <= 4'd0;
      gfx    <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      gfx    <= gfx_n;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb/tb_sprite_line_renderer.sv - directed self-checking bench for sprite_line_renderer
module tb_sprite_line_renderer;
  import sprite_line_renderer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos, sprite_x, sprite_y;
  logic       gfx, busy;

  sprite_line_renderer_if rom_if();

  sprite_line_renderer dut (
    .clk      (clk),
    .reset    (reset),
    .hpos     (hpos),
    .vpos     (vpos),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y),
    .rom      (rom_if),
    .gfx      (gfx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [16];
  always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

  typedef struct {
    int         sx, sy;
    logic [7:0] fill;
    bit         rowid;
    int         lo, hi;
    int         n_on, hmin, hmax, vmin, vmax;
  } vec_t;

  vec_t       vecs [4];
  int         n_tests = 0, n_fail = 0;
  int         mx = 1023, my = 1023;
  int         line_ones [1024];
  logic [3:0] addr641 [1024];
  logic       busy641 [1024];
  int         s_on, s_hmin, s_hmax, s_vmin, s_vmax;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_pix(input int v, input int h);
    int row, d;
    if (v >= 480 || h >= 640 || mx > 799) return 1'b0;
    if (v < my || v - my >= 16) return 1'b0;
    row = v - my;
    d = (h - mx + 800) % 800;
    if (d > 7) return 1'b0;
    return rom_mem[row][7 - d];
  endfunction

  task automatic fill_rom(input logic [7:0] fill, input bit rowid);
    for (int k = 0; k < 16; k++) rom_mem[k] = rowid ? (8'h80 >> (k % 8)) : fill;
  endtask

  task automatic cyc(input int v, input int h);
    @(posedge clk);
    #1;
    vpos = 10'(v);
    hpos = 10'(h);
    @(negedge clk);
  endtask

  task automatic run_span(input int v, input int h0, input int h1, input bit chk);
    bit   bad;
    logic e;
    bad = 1'b0;
    for (int h = h0; h <= h1; h++) begin
      cyc(v, h);
      e = exp_pix(v, h);
      if (chk) begin
        if (gfx !== e && !bad) begin
          bad = 1'b1;
          $display("FAIL gfx line %0d hpos %0d: got %b expected %b", v, h, gfx, e);
        end
        if (gfx === 1'b1) begin
          line_ones[v]++;
          s_on++;
          if (h < s_hmin) s_hmin = h;
          if (h > s_hmax) s_hmax = h;
          if (v < s_vmin) s_vmin = v;
          if (v > s_vmax) s_vmax = v;
        end
      end
      if (h == 641) begin
        addr641[v] = rom_if.rom_addr;
        busy641[v] = busy;
      end
      if (v == 480 && h == 0) begin
        mx = sprite_x;
        my = sprite_y;
      end
    end
    if (chk) begin
      n_tests++;
      if (bad) n_fail++;
    end
  endtask

  task automatic run_line(input int v, input bit chk);
    line_ones[v] = 0;
    run_span(v, 0, 799, chk);
  endtask

  task automatic latch_frame();
    cyc(480, 0);
    mx = sprite_x;
    my = sprite_y;
  endtask

  task automatic clear_stats();
    s_on = 0; s_hmin = 9999; s_hmax = -1; s_vmin = 9999; s_vmax = -1;
  endtask

  initial begin
    vecs[0] = '{sx:100, sy:50,  fill:8'hA5, rowid:0, lo:49,  hi:66,  n_on:64,  hmin:100, hmax:107, vmin:50,  vmax:65};
    vecs[1] = '{sx:636, sy:50,  fill:8'hFF, rowid:0, lo:64,  hi:66,  n_on:8,   hmin:636, hmax:639, vmin:64,  vmax:65};
    vecs[2] = '{sx:0,   sy:0,   fill:8'hFF, rowid:0, lo:0,   hi:2,   n_on:24,  hmin:0,   hmax:7,   vmin:0,   vmax:2};
    vecs[3] = '{sx:300, sy:470, fill:8'h00, rowid:1, lo:469, hi:481, n_on:10,  hmin:300, hmax:307, vmin:470, vmax:479};

    fill_rom(8'hA5, 1'b0);
    reset = 1'b1; hpos = 10'd0; vpos = 10'd0; sprite_x = 10'd0; sprite_y = 10'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_gfx", gfx, 0);
    check("reset_busy", busy, 0);
    check("reset_rom_addr", rom_if.rom_addr, 0);

    // Offscreen latches after reset: nothing may draw before a frame latch.
    run_line(524, 0);
    check("no_fetch_before_latch", busy641[524], 0);
    run_line(0, 1);
    run_line(1, 1);

    foreach (vecs[i]) begin
      sprite_x = 10'(vecs[i].sx);
      sprite_y = 10'(vecs[i].sy);
      fill_rom(vecs[i].fill, vecs[i].rowid);
      latch_frame();
      run_line((vecs[i].lo == 0) ? 524 : vecs[i].lo - 1, 0);
      clear_stats();
      for (int v = vecs[i].lo; v <= vecs[i].hi; v++) run_line(v, 1);
      check($sformatf("v%0d_count", i), s_on, vecs[i].n_on);
      check($sformatf("v%0d_hmin", i), s_hmin, vecs[i].hmin);
      check($sformatf("v%0d_hmax", i), s_hmax, vecs[i].hmax);
      check($sformatf("v%0d_vmin", i), s_vmin, vecs[i].vmin);
      check($sformatf("v%0d_vmax", i), s_vmax, vecs[i].vmax);
      if (i == 2) begin
        check("addr_at_524_640", addr641[524], 0);
        check("busy_at_524_641", busy641[524], 1);
      end
      if (i == 3) begin
        check("addr_row0_line469", addr641[469], 0);
        check("addr_row9_line478", addr641[478], 9);
        check("addr_held_line479", addr641[479], 9);
        check("no_fetch_t480", busy641[479], 0);
        check("no_fetch_t481", busy641[480], 0);
      end
    end

    // Mid-frame sprite_y change only takes effect at the next frame latch.
    sprite_x = 10'd100; sprite_y = 10'd50;
    fill_rom(8'hA5, 1'b0);
    latch_frame();
    run_line(49, 0);
    run_line(50, 1);
    run_line(54, 0);
    sprite_y = 10'd200;
    run_line(55, 1);
    run_line(64, 0);
    run_line(65, 1);
    run_line(66, 1);
    check("ymove_old_line55", line_ones[55], 4);
    check("ymove_old_line65", line_ones[65], 4);
    check("ymove_old_line66", line_ones[66], 0);
    run_line(480, 0);
    run_line(199, 1);
    run_line(200, 1);
    run_line(214, 0);
    run_line(215, 1);
    run_line(216, 1);
    check("ymove_new_line200", line_ones[200], 4);
    check("ymove_new_line215", line_ones[215], 4);
    check("ymove_new_line216", line_ones[216], 0);

    // Reset while drawing: the row is dropped and the block idles.
    sprite_y = 10'd50;
    latch_frame();
    run_line(49, 0);
    run_span(50, 0, 102, 1);
    cyc(50, 103);
    check("draw_busy_h103", busy, 1);
    check("draw_gfx_h103", gfx, 0);
    reset = 1'b1;
    cyc(50, 104);
    check("rst_gfx_h104", gfx, 0);
    check("rst_busy_h104", busy, 0);
    reset = 1'b0;
    mx = 1023; my = 1023;
    cyc(50, 105);
    check("rst_gfx_h105", gfx, 0);
    check("rst_busy_h105", busy, 0);
    run_span(50, 106, 799, 1);
    latch_frame();
    run_line(50, 0);
    run_line(51, 1);
    check("after_reset_line51", line_ones[51], 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Single-sprite scanline renderer fed by the `hvsync_generator` beam position (`hpos`/`vpos`). It produces a 1-bit `gfx` pixel stream, combined downstream into `rgb` alongside `display_on`. Each horizontal blank it fetches one 8-pixel row of a 8x16 monochrome bitmap from a registered ROM and shifts that row out, pixel-aligned, on the following visible line. Sprite position is sampled once per frame, so moves never tear mid-frame.

## Interface
- `H_DISPLAY`, 640: visible pixels per line.
- `H_MAX`, 799: last `hpos` value before wrap to 0.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_MAX`, 524: last `vpos` value before wrap to 0.
- `clk` in 1: pixel clock, the same clock driving `hvsync_generator`.
- `reset` in 1: synchronous, active-high.
- `hpos` in 10: current beam column.
- `vpos` in 10: current beam line.
- `sprite_x` in 10: requested left column. Sampled per frame.
- `sprite_y` in 10: requested top line. Sampled per frame.
- `rom_addr` out 4: bitmap row index. Registered.
- `rom_data` in 8: bitmap row. Valid exactly 1 cycle after `rom_addr` changes. Bit 7 is the leftmost pixel.
- `gfx` out 1: sprite pixel for the current `hpos`. Registered.
- `busy` out 1: high whenever FSM ≠ IDLE.

## Operation
- Frame latch: on the cycle `vpos==V_DISPLAY && hpos==0`, capture `x_lat<=sprite_x` and `y_lat<=sprite_y`. No other cycle updates them.
- Line trigger: the cycle `hpos==H_DISPLAY`.
  - Target line `t = (vpos==V_MAX) ? 0 : vpos+1`.
  - Row `r = t - y_lat`, computed at 10 bits.
  - Hit when `t >= y_lat && r < 16 && t < V_DISPLAY`.
- Next-column compare: `hn = (hpos==H_MAX) ? 0 : hpos+1`.
- FSM states: IDLE, FETCH, LOAD, ARMED, DRAW.
  - Any state, on line trigger with hit: go to FETCH and set `rom_addr<=r[3:0]`. This aborts any in-flight draw.
  - Any state, on line trigger with no hit: go to IDLE.
  - FETCH → LOAD after 1 cycle (ROM latency).
  - LOAD: `shreg<=rom_data`, then go to ARMED.
  - ARMED: when `hn==x_lat`, go to DRAW and set `gfx<=shreg[7]`, `shreg<=shreg<<1`, `cnt<=7`.
  - DRAW: while `cnt≠0`, set `gfx<=shreg[7]`, shift, and decrement `cnt`. When `cnt==0`, set `gfx<=0` and go to IDLE.
- `gfx` is 0 in every state except DRAW.
- `gfx` is forced 0 whenever the pixel it represents has column ≥ `H_DISPLAY`. The right-edge clip is done in-block.
- `x_lat ≥ H_DISPLAY`: ARMED never matches a visible column. Any match in blank is clipped. The next line trigger returns the FSM to IDLE.
- `rom_addr` holds its last value outside FETCH.

## Timing
- Reset values:
  - state IDLE, `gfx=0`, `busy=0`, `rom_addr=0`, `shreg=0`, `cnt=0`.
  - `x_lat=y_lat=10'h3FF`, i.e. offscreen, so nothing draws before the first frame latch.
- Reset mid-operation: the next cycle is IDLE with `gfx=0`. The in-flight row is discarded.
- Fetch latency: row data is in `shreg` 2 cycles after the line trigger. The ARMED wait spans the rest of hblank.
- Pixel alignment: sprite column j appears on `gfx` in the cycle where `hpos == x_lat + j` (mod `H_MAX+1`), on line t. Latency is zero relative to the beam; the compare uses `hn` to absorb the output register.
- `x_lat==0`: the match occurs at `hpos==H_MAX` of line t−1, so column 0 is drawn at `hpos==0`.
- Frame latch and line trigger never coincide, since they occur at different `hpos` values.

## Structure
- Shared timing package/header: `H_DISPLAY`, `H_MAX`, `V_DISPLAY`, `V_MAX`, shared with `hvsync_generator`. Also holds the FSM state encoding constants (3-bit).
- No sub-module required.
- Bitmap ROM lives outside the block, at the instantiating top level, so different sprites reuse this RTL.

## Test plan
- Reset, then `sprite_x=100`, `sprite_y=50`, ROM row k = `8'hA5` for all k. Over one full frame, `gfx` must:
  - be high exactly at `hpos∈{100,102,105,107}`;
  - do so on lines 50..65 only;
  - stay 0 elsewhere.
- `sprite_x=636`, ROM `8'hFF`: `gfx` high only at `hpos` 636..639 on sprite lines, 0 at 640..643.
- `sprite_x=0`, `sprite_y=0`: line 0 `hpos` 0..7 shows row 0. `rom_addr==0` is driven at `vpos=524`, `hpos=640`.
- Change `sprite_y` from 50 to 200 at `vpos=55`: the current frame still draws lines 50..65. The next frame draws lines 200..215.
- Assert `reset` during DRAW at `hpos=103`: `gfx=0` and `busy=0` on the next cycle. The following line draws normally after `reset` drops.
- `sprite_y=470`: rows 0..9 are drawn on lines 470..479. No ROM fetch and no `gfx` occur for `t≥480`.
